// File: rtl/tl_write_back_pipe.sv
// tl_write_back_pipe
// Pipelined write-back stage. Holds the MEM/WB pipeline register, which
// supports stall, flush and a valid bit. From the registered state it
// selects what is written back: the ALU result, the extracted and extended
// load data, or the link address. It also counts committed register writes
// for debug.
//
// Ports:
//   i_clock, i_reset      clock and synchronous active-high reset
//   i_valid               MEM stage holds a valid instruction
//   i_stall, i_flush      hold / bubble the MEM/WB register (flush wins)
//   i_read_data           raw word from data memory
//   i_result_alu          ALU result; bits [1:0] give the load byte offset
//   i_pc_link             return address for link instructions
//   i_write_reg           destination register
//   i_senial_control      [0] RegWrite [1] MemtoReg [2] Link
//                         [4:3] load size (00 byte, 01 half, 1x word)
//                         [5] unsigned load
//   o_write_data          register-file write data
//   o_write_reg           register-file write address (always driven)
//   o_reg_write           register-file write enable (never for r0)
//   o_fwd_data            copy of o_write_data for the forwarding unit
//   o_retired             wrapping count of committed register writes
module tl_write_back_pipe #(
    parameter int len               = 32,
    parameter int NB_SENIAL_CONTROL = 8,
    parameter int NB_ADDR_REG       = 5,
    parameter int NB_RETIRED        = 16
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic                         i_valid,
    input  logic                         i_stall,
    input  logic                         i_flush,
    input  logic [len-1:0]               i_read_data,
    input  logic [len-1:0]               i_result_alu,
    input  logic [len-1:0]               i_pc_link,
    input  logic [NB_ADDR_REG-1:0]       i_write_reg,
    input  logic [NB_SENIAL_CONTROL-1:0] i_senial_control,
    output logic [len-1:0]               o_write_data,
    output logic [NB_ADDR_REG-1:0]       o_write_reg,
    output logic                         o_reg_write,
    output logic [len-1:0]               o_fwd_data,
    output logic [NB_RETIRED-1:0]        o_retired
);

    // Control bit positions inside the control word
    localparam int CTRL_REG_WRITE = 0;
    localparam int CTRL_MEM_TO_REG = 1;
    localparam int CTRL_LINK = 2;
    localparam int CTRL_UNSIGNED = 5;

    // Only the low six control bits mean anything to this stage, so only
    // those are kept in the pipeline register.
    logic                   wb_valid;
    logic [5:0]             wb_ctrl;
    logic [len-1:0]         wb_read_data;
    logic [len-1:0]         wb_result_alu;
    logic [len-1:0]         wb_pc_link;
    logic [NB_ADDR_REG-1:0] wb_write_reg;
    logic [NB_RETIRED-1:0]  retired_count;

    logic [1:0]             load_offset;
    logic [7:0]             byte_lane;
    logic [15:0]            half_lane;
    logic [len-1:0]         load_data;

    // The upper control bits are reserved for other stages.
    generate
        if (NB_SENIAL_CONTROL > 6) begin : g_spare_ctrl
            logic unused_ctrl_bits;
            assign unused_ctrl_bits = &{1'b0, i_senial_control[NB_SENIAL_CONTROL-1:6]};
        end
    endgenerate

    // MEM/WB register. A flush clears only valid and control, which is
    // enough to make the slot a bubble. The data fields keep their values.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            wb_valid      <= 1'b0;
            wb_ctrl       <= '0;
            wb_read_data  <= '0;
            wb_result_alu <= '0;
            wb_pc_link    <= '0;
            wb_write_reg  <= '0;
        end else if (i_flush) begin
            wb_valid <= 1'b0;
            wb_ctrl  <= '0;
        end else if (!i_stall) begin
            wb_valid      <= i_valid;
            wb_ctrl       <= i_senial_control[5:0];
            wb_read_data  <= i_read_data;
            wb_result_alu <= i_result_alu;
            wb_pc_link    <= i_pc_link;
            wb_write_reg  <= i_write_reg;
        end
    end

    // Retired-write counter. An instruction only counts on the edge where
    // it actually leaves the stage. A stalled write therefore counts once,
    // and a write that is flushed or reset away does not count.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            retired_count <= '0;
        end else if (o_reg_write && !i_stall && !i_flush) begin
            retired_count <= retired_count + 1'b1;
        end
    end

    // Load lane extraction (little-endian). For halfword loads only the
    // upper offset bit matters, so a misaligned half is quietly rounded
    // down instead of trapping.
    always_comb begin
        load_offset = wb_result_alu[1:0];
        byte_lane   = 8'(wb_read_data >> {load_offset, 3'b000});
        half_lane   = 16'(wb_read_data >> {load_offset[1], 4'b0000});
        load_data   = wb_read_data;
        if (!wb_ctrl[4]) begin
            if (!wb_ctrl[3]) begin
                load_data = wb_ctrl[CTRL_UNSIGNED]
                          ? {{(len-8){1'b0}}, byte_lane}
                          : {{(len-8){byte_lane[7]}}, byte_lane};
            end else begin
                load_data = wb_ctrl[CTRL_UNSIGNED]
                          ? {{(len-16){1'b0}}, half_lane}
                          : {{(len-16){half_lane[15]}}, half_lane};
            end
        end
    end

    // Write-back source select. Link overrides MemtoReg so that a
    // jump-and-link always writes its return address.
    always_comb begin
        if (wb_ctrl[CTRL_LINK]) begin
            o_write_data = wb_pc_link;
        end else if (wb_ctrl[CTRL_MEM_TO_REG]) begin
            o_write_data = load_data;
        end else begin
            o_write_data = wb_result_alu;
        end
    end

    assign o_fwd_data  = o_write_data;
    assign o_write_reg = wb_write_reg;
    assign o_reg_write = wb_valid && wb_ctrl[CTRL_REG_WRITE] && (wb_write_reg != '0);
    assign o_retired   = retired_count;

endmodule
